// File: rtl/complex_stream_unpacker.sv
// rtl/complex_stream_unpacker.sv - rebuilds packed complex amplitudes from a byte link into state-vector RAM writes
module complex_stream_unpacker #(
  parameter int NUM_QUBITS = 3,
  parameter int ADDR_W     = NUM_QUBITS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done
);

  localparam int DEPTH = 2 ** NUM_QUBITS;
  localparam logic [ADDR_W-1:0] LAST_AMP = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FINISH
  } state_t;

  state_t            r_state;
  logic [1:0]        r_byte_cnt;
  logic [ADDR_W-1:0] r_amp_cnt;
  logic [23:0]       r_shift;

  logic w_accept;
  assign w_accept = byte_valid && byte_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_byte_cnt <= '0;
      r_amp_cnt  <= '0;
      r_shift    <= '0;
      byte_ready <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_LOAD;
            r_byte_cnt <= '0;
            r_amp_cnt  <= '0;
            byte_ready <= 1'b1;
            busy       <= 1'b1;
          end
        end
        S_LOAD: begin
          // abort takes priority and drops any byte offered in the same cycle
          if (abort) begin
            r_state    <= S_IDLE;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
          end else if (w_accept) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_shift    <= {r_shift[15:0], byte_in};
            if (r_byte_cnt == 2'd3) begin
              wr_en     <= 1'b1;
              wr_addr   <= r_amp_cnt;
              wr_data   <= {r_shift, byte_in};
              r_amp_cnt <= r_amp_cnt + 1'b1;
              if (r_amp_cnt == LAST_AMP) begin
                r_state    <= S_FINISH;
                byte_ready <= 1'b0;
                busy       <= 1'b0;
              end
            end
          end
        end
        S_FINISH: begin
          done    <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_complex_stream_unpacker.sv
// tb/tb_complex_stream_unpacker.sv - scoreboard bench for complex_stream_unpacker
module tb_complex_stream_unpacker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;

  complex_stream_unpacker #(.NUM_QUBITS(3), .ADDR_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int wr_seen = 0;
  int done_seen = 0;
  int cyc = 0;
  int last_wr_cyc = -1;
  bit b2b_mode = 1'b0;

  logic [34:0] exp_q[$];
  int          tb_bcnt;
  logic [31:0] tb_word;
  logic [2:0]  exp_amp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n && done) done_seen++;
    if (rst_n && wr_en) begin
      wr_seen++;
      if (b2b_mode && last_wr_cyc >= 0) chk("wr_spacing", 64'(cyc - last_wr_cyc), 64'd4);
      last_wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_wr", {29'd0, wr_addr, wr_data}, 64'h7_FFFF_FFFF);
      end else begin
        chk("wr_addr_data", {29'd0, wr_addr, wr_data}, {29'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    bit rdy;
    for (int i = 0; i < gap; i++) begin
      byte_valid = 1'b0;
      @(posedge clk); #1;
    end
    byte_valid = 1'b1;
    byte_in    = b;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      rdy = byte_ready;
      @(posedge clk); #1;
      ok = rdy;
    end
    if (!ok) chk("byte_accept_timeout", 64'd0, 64'd1);
    tb_word = {tb_word[23:0], b};
    tb_bcnt++;
    if (tb_bcnt == 4) begin
      exp_q.push_back({exp_amp, tb_word});
      exp_amp++;
      tb_bcnt = 0;
    end
  endtask

  task automatic send_amp(input logic [31:0] w, input int maxgap);
    for (int i = 3; i >= 0; i--) begin
      send_byte(w[i*8 +: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    tb_bcnt = 0;
    exp_amp = 3'd0;
    last_wr_cyc = -1;
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    chk("ready_after_start", {63'd0, byte_ready}, 64'd1);
  endtask

  task automatic finish_check(input string tag);
    byte_valid = 1'b0;
    chk({tag, "_last_wr_en"}, {63'd0, wr_en}, 64'd1);
    chk({tag, "_ready_drop"}, {62'd0, byte_ready, busy}, 64'd0);
    @(posedge clk); #1;
    chk({tag, "_done"}, {62'd0, done, wr_en}, 64'd2);
    @(posedge clk); #1;
    chk({tag, "_done_clear"}, {62'd0, done, busy}, 64'd0);
    chk({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic load_full(input logic [31:0] first, input bit rnd, input int maxgap, input string tag);
    int w0;
    int d0;
    w0 = wr_seen;
    d0 = done_seen;
    do_start();
    send_amp(first, maxgap);
    for (int k = 1; k < 8; k++) send_amp(rnd ? 32'($urandom) : 32'd0, maxgap);
    finish_check(tag);
    chk({tag, "_wr_count"}, 64'(wr_seen - w0), 64'd8);
    chk({tag, "_done_count"}, 64'(done_seen - d0), 64'd1);
  endtask

  initial begin
    int w0;
    int d0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; byte_in = 8'd0; byte_valid = 1'b0;
    tb_bcnt = 0; tb_word = 32'd0; exp_amp = 3'd0;
    #3;
    chk("reset_outputs", {25'd0, byte_ready, wr_en, wr_addr, wr_data, busy, done}, 64'd0);
    #3 rst_n = 1'b1;

    // bytes offered while idle are ignored
    byte_valid = 1'b1;
    byte_in    = 8'h55;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("idle_ready_low", {63'd0, byte_ready}, 64'd0);
    end
    byte_valid = 1'b0;
    chk("idle_no_writes", 64'(wr_seen), 64'd0);

    b2b_mode = 1'b1;
    load_full(32'h2000_0000, 1'b0, 0, "basic");
    load_full(32'hE000_16A1, 1'b1, 0, "bitexact");
    b2b_mode = 1'b0;
    load_full(32'h2000_0000, 1'b0, 2, "gapped");

    // abort after 1 amplitude + 2 bytes; byte offered with abort is dropped
    w0 = wr_seen;
    d0 = done_seen;
    do_start();
    send_amp(32'h1122_3344, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    abort      = 1'b1;
    byte_valid = 1'b1;
    byte_in    = 8'h77;
    @(posedge clk); #1;
    abort      = 1'b0;
    byte_valid = 1'b0;
    tb_bcnt    = 0;
    chk("abort_idle", {62'd0, busy, byte_ready}, 64'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("abort_wr_count", 64'(wr_seen - w0), 64'd1);
    chk("abort_no_done", 64'(done_seen - d0), 64'd0);
    load_full(32'hDEAD_BEEF, 1'b1, 0, "after_abort");

    // start mid-word must not reset counters
    w0 = wr_seen;
    do_start();
    send_amp(32'hA5A5_0001, 0);
    send_amp(32'hA5A5_0002, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    byte_valid = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    send_byte(8'h56, 0);
    send_byte(8'h78, 0);
    for (int k = 3; k < 8; k++) send_amp(32'($urandom), 0);
    finish_check("start_mid");
    chk("start_mid_wr_count", 64'(wr_seen - w0), 64'd8);

    // reset after byte 10
    w0 = wr_seen;
    do_start();
    send_amp(32'h0102_0304, 0);
    send_amp(32'h0506_0708, 0);
    send_byte(8'h09, 0);
    send_byte(8'h0A, 0);
    rst_n = 1'b0;
    byte_valid = 1'b0;
    #1;
    chk("midreset_outputs", {25'd0, byte_ready, wr_en, wr_addr, wr_data, busy, done}, 64'd0);
    tb_bcnt = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midreset_wr_count", 64'(wr_seen - w0), 64'd2);
    chk("midreset_queue", 64'(exp_q.size()), 64'd0);
    load_full(32'hCAFE_F00D, 1'b1, 1, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/complex_stream_unpacker.md
Name: complex_stream_unpacker

Overview:
- Byte-stream receiver that rebuilds complex_t amplitudes (Q3.13 re/im, 16 bits each) from a host byte link.
- Writes each amplitude into the state-vector RAM at sequential addresses.
- Inverse of the amplitude packer/readout path.
- Loads a full 2^NUM_QUBITS state vector for each start command.

Parameters:
NUM_QUBITS, 3, qubit count; state vector depth DEPTH = 2**NUM_QUBITS
ADDR_W, NUM_QUBITS, RAM address width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins a load of DEPTH amplitudes
abort  in  1  single-cycle pulse; cancels the load in progress
byte_in  in  8  incoming byte
byte_valid  in  1  byte_in valid
byte_ready  out  1  unpacker accepts a byte this cycle
wr_en  out  1  RAM write strobe, one cycle
wr_addr  out  ADDR_W  RAM write address
wr_data  out  32  packed complex_t {re[15:0], im[15:0]}
busy  out  1  high while in LOAD
done  out  1  one-cycle pulse after the last amplitude is written

Behaviour:
- Reset (async, rst_n=0):
  - FSM=IDLE; byte counter=0; amplitude counter=0.
  - All outputs 0 (byte_ready, wr_en, wr_addr, wr_data, busy, done).
- Byte handshake: a byte is accepted on a rising edge with byte_valid && byte_ready. byte_valid may drop at any time with no penalty.
- FSM states:
  - IDLE:
    - byte_ready=0; bytes presented are ignored, not counted.
    - start=1 -> LOAD; byte_cnt and amp_cnt cleared.
  - LOAD:
    - busy=1; byte_ready=1 every cycle; there is no internal stall.
    - Byte order per amplitude is big-endian: re[15:8], re[7:0], im[15:8], im[7:0].
    - byte_cnt (2-bit) increments per accepted byte and wraps 3 -> 0.
    - On acceptance of the 4th byte:
      - Next cycle: wr_en=1, wr_addr=amp_cnt, wr_data = assembled 32 bits.
      - amp_cnt then increments.
    - If that was amplitude DEPTH-1: the next state is FINISH and byte_ready drops in the same cycle that wr_en asserts.
  - FINISH: done=1 for exactly one cycle, busy=0 -> IDLE.
- Latency: last byte accepted at cycle N -> wr_en at N+1 -> done at N+2 for the final amplitude.
- wr_en is a registered one-cycle pulse. Back-to-back amplitudes (a byte every cycle) give wr_en every 4th cycle.
- Data is passed bit-exact; no saturation or rescaling. Values are Q3.13 as sent.
- start while in LOAD or FINISH: ignored.
- abort in LOAD:
  - Next state IDLE; partial amplitude bytes discarded; no wr_en for the partial word; no done.
  - RAM contents already written are not reverted.
  - A byte accepted in the same cycle as abort is discarded.
  - abort in IDLE or FINISH: ignored.
- start and abort in the same cycle while in IDLE: start wins (-> LOAD).
- Reset mid-load: immediate return to IDLE. A pending wr_en is cleared and not issued.
- wr_addr and wr_data hold their last values when wr_en=0.

Test Plan:
- Basic load, NUM_QUBITS=3: start, then 32 bytes back-to-back encoding amp k re=16'h2000 (1.0) for k=0 and 16'h0000 otherwise, im=0 -> 8 wr_en pulses 4 cycles apart; addr 0..7; addr0 data 32'h2000_0000; done 2 cycles after byte 32; busy low after.
- Negative/bit-exact: amplitude bytes 8'hE0,8'h00,8'h16,8'hA1 -> wr_data=32'hE000_16A1 (re=-1.0, im≈0.7071).
- Gapped valid: random byte_valid deassertion over 32 bytes -> same addresses and data as the back-to-back case; no extra or missing wr_en.
- Abort after 6 bytes (1 amp + 2 bytes) -> exactly one wr_en (addr 0); no done; IDLE. A new start then writes addr 0 again.
- Idle bytes and start while busy: 5 valid bytes before start -> byte_ready=0 and no writes. start pulsed mid-load -> no counter reset; addresses continue in order.
- Reset mid-load: rst_n low after byte 10 -> all outputs 0 immediately; no wr_en for the pending amp 2. After release and start -> load begins at addr 0.
